mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multicycle MIPS-subset control FSM; it is the initiator that drives the 4-bit operation code into the datapath ALU.
- Decodes the opcode/funct held in the datapath IR and sequences fetch, decode, execute, memory and writeback.
- Emits datapath enables, mux selects and the ALU opcode; handshakes with instruction/data memory.
- Consumes the ALU flag as the branch condition.

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before the ERR state (range 2..255)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU flag; valid the cycle after compare op 0111 is applied
mem_ready  in  1  memory access completes this cycle
mem_req  out  1  memory access request
mem_write  out  1  request is a write
iord  out  1  0 = PC address, 1 = ALUOut address
ir_write  out  1  load IR
pc_en  out  1  PC write enable (already branch-qualified)
pc_src  out  2  0 ALU, 1 ALUOut, 2 jump target
alu_src_a  out  1  0 PC, 1 regA
alu_src_b  out  2  0 regB, 1 const 4, 2 sign-ext imm, 3 imm<<2
alu_op  out  4  ALU operation code
reg_write  out  1  register file write
reg_dst  out  1  0 rt, 1 rd
mem_to_reg  out  1  0 ALUOut, 1 MDR
err  out  1  sticky memory-timeout error
state_dbg  out  4  current state encoding

Behaviour:
- Clock/reset: clk; reset_n async active-low. In reset: state=FETCH, wait counter=0, err=0, all outputs 0. Outputs are Moore-decoded from the state; all are forced 0 while reset_n is low.
- ALU codes: 0000 AND, 0001 OR, 0010 ADD, 0011 NOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 CMP (sets zero = (x-y)!=0; no RESULT), 1000 SRA.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD.
  - On mem_ready: ir_write=1, pc_en=1, pc_src=0, go to DECODE. Otherwise hold.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target). Next state by opcode:
  - 000000 R-type -> RTEX
  - 100011 lw, 101011 sw -> MEMADR
  - 000100 beq, 000101 bne -> BRANCH
  - 001000 addi, 001100 andi, 001101 ori -> IMMEX
  - 000010 j -> JUMP
  - other -> FETCH (NOP)
- RTEX:
  - alu_src_a=1, alu_src_b=0.
  - funct 100100 AND, 100101 OR, 100000 ADD, 100111 NOR, 100010 SUB; 000000 SLL, 000010 SRL, 000011 SRA (shamt supplied by datapath).
  - Unknown funct: alu_op=ADD, writeback still occurs.
  - Next: RTWB.
- RTWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- MEMADR: alu_src_a=1, alu_src_b=2, ADD -> MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req=1, iord=1; hold until mem_ready -> MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1; hold until mem_ready -> FETCH.
- BRANCH:
  - Cycle 1 applies alu_op=0111 (alu_src_a=1, alu_src_b=0).
  - Cycle 2 (internal BRWAIT substate) samples zero; pc_src=1.
  - pc_en = ~zero for beq, zero for bne. Then -> FETCH.
- IMMEX: alu_src_a=1, alu_src_b=2; alu_op ADD/AND/OR per opcode -> IMMWB.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- JUMP: pc_en=1, pc_src=2 -> FETCH.
- Memory wait and timeout:
  - The counter counts consecutive cycles with mem_req=1 and mem_ready=0.
  - Counter reaching MEM_TIMEOUT -> ERR.
  - Counter clears on mem_ready or on leaving a memory state.
  - mem_ready in the first cycle of a request is a zero-wait access.
- ERR: err=1 and all other outputs 0. Exit only via reset.
- mem_ready while mem_req=0: ignored.
- Reset mid-access: state returns to FETCH immediately and mem_req drops asynchronously.

Optional Feature:
- Macro: MC_CONTROL_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output illegal_op (1 bit) and state TRAP.
  - Unknown opcode in DECODE, or unknown funct in RTEX, -> TRAP.
  - TRAP asserts illegal_op=1 and pc_en=1 with pc_src=2 (datapath presents the vector) for one cycle, then -> FETCH.
  - In RTEX with unknown funct, reg_write is suppressed.
- Undefined: no port, unknown opcode behaves as NOP, unknown funct executes ADD.

Decomposition:
- Shared package holds:
  - ALU opcode localparams, ALU_AND through ALU_SRA.
  - Opcode and funct localparams.
  - State encodings.
  - alu_src_b and pc_src select constants.
- Natural sub-module: mc_alu_decode, a combinational mapping of (state class, opcode, funct) to alu_op. It is shared with single-cycle variants.

Test Plan:
- add $3,$1,$2 (op 0, funct 100000), mem_ready=1 each request -> FETCH,DECODE,RTEX(alu_op 0010),RTWB(reg_write=1, reg_dst=1); 4 cycles.
- lw with mem_ready delayed 3 cycles in MEMRD -> mem_req held 4 cycles, MEMWB mem_to_reg=1; total 5+3 cycles.
- beq with zero=0 -> pc_en=1, pc_src=1 in BRWAIT; beq with zero=1 -> pc_en=0; bne mirrored.
- mem_ready held 0 in FETCH, MEM_TIMEOUT=4 -> ERR after 4 wait cycles, err=1 sticky until reset_n low.
- reset_n asserted in MEMWR mid-wait -> mem_req/mem_write drop same cycle; state_dbg=FETCH after release.
- opcode 111111 -> with macro: illegal_op pulse 1 cycle, pc_src=2; without: return to FETCH, no writes.

Source files
------------

// File: rtl/mc_control_pkg.sv
// Shared constants for the multicycle MIPS-subset controller: ALU codes,
// opcode/funct values, FSM states, datapath select values and the control word.
package mc_control_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_NOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_CMP = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;

  localparam logic [1:0] SRCB_REGB   = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_BRWAIT = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_JUMP   = 4'd12,
    S_ERR    = 4'd13,
    S_TRAP   = 4'd14
  } state_t;

  // Which flavour of ALU operation the current state needs.
  typedef enum logic [1:0] {
    CLS_ADD   = 2'd0,
    CLS_RTYPE = 2'd1,
    CLS_IMM   = 2'd2,
    CLS_CMP   = 2'd3
  } alu_cls_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       err;
  } ctl_t;

  function automatic logic is_known_funct(input logic [5:0] fn);
    return (fn == FN_AND) || (fn == FN_OR) || (fn == FN_ADD) || (fn == FN_NOR) ||
           (fn == FN_SUB) || (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
  endfunction

endpackage

// File: rtl/mc_control_alu_decode.sv
// Combinational ALU opcode selection from (state class, opcode, funct);
// also used by the single-cycle controller variants.
module mc_alu_decode
  import mc_control_pkg::*;
(
  input  alu_cls_t   cls_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_op_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    case (cls_i)
      CLS_RTYPE: begin
        case (funct_i)
          FN_AND:  alu_op_o = ALU_AND;
          FN_OR:   alu_op_o = ALU_OR;
          FN_ADD:  alu_op_o = ALU_ADD;
          FN_NOR:  alu_op_o = ALU_NOR;
          FN_SUB:  alu_op_o = ALU_SUB;
          FN_SLL:  alu_op_o = ALU_SLL;
          FN_SRL:  alu_op_o = ALU_SRL;
          FN_SRA:  alu_op_o = ALU_SRA;
          default: alu_op_o = ALU_ADD;
        endcase
      end
      CLS_IMM: begin
        case (opcode_i)
          OP_ANDI: alu_op_o = ALU_AND;
          OP_ORI:  alu_op_o = ALU_OR;
          default: alu_op_o = ALU_ADD;
        endcase
      end
      CLS_CMP: alu_op_o = ALU_CMP;
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS-subset control FSM with memory-wait timeout.
// Define MC_CONTROL_ILLEGAL_TRAP_EN to trap unknown opcodes/functs via state TRAP.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       err,
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  output logic       illegal_op,
`endif
  output logic [3:0] state_dbg
);

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  alu_cls_t   cls;
  logic [3:0] dec_alu_op;
  ctl_t       ctl, ctl_g;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  logic       illegal_c;
`endif

  always_comb begin
    case (state_q)
      S_RTEX:   cls = CLS_RTYPE;
      S_IMMEX:  cls = CLS_IMM;
      S_BRANCH: cls = CLS_CMP;
      default:  cls = CLS_ADD;
    endcase
  end

  mc_alu_decode u_alu_decode (
    .cls_i    (cls),
    .opcode_i (opcode),
    .funct_i  (funct),
    .alu_op_o (dec_alu_op)
  );

  always_comb begin
    ctl     = '0;
    state_d = state_q;
    cnt_d   = 8'd0;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    illegal_c = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        ctl.mem_req   = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = dec_alu_op;
        if (mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_en    = 1'b1;
          ctl.pc_src   = PCSRC_ALU;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        ctl.alu_src_b = SRCB_IMM_SH;
        ctl.alu_op    = dec_alu_op;
        case (opcode)
          OP_RTYPE:                  state_d = S_RTEX;
          OP_LW, OP_SW:              state_d = S_MEMADR;
          OP_BEQ, OP_BNE:            state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IMMEX;
          OP_J:                      state_d = S_JUMP;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
          default:                   state_d = S_TRAP;
`else
          default:                   state_d = S_FETCH;
`endif
        endcase
      end
      S_RTEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_REGB;
        ctl.alu_op    = dec_alu_op;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
        state_d = is_known_funct(funct) ? S_RTWB : S_TRAP;
`else
        state_d = S_RTWB;
`endif
      end
      S_RTWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = dec_alu_op;
        state_d       = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctl.mem_req = 1'b1;
        ctl.iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWR: begin
        ctl.mem_req   = 1'b1;
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_REGB;
        ctl.alu_op    = dec_alu_op;
        state_d       = S_BRWAIT;
      end
      S_BRWAIT: begin
        // IR still holds the branch; opcode bit 0 separates bne from beq.
        ctl.pc_src = PCSRC_ALUOUT;
        ctl.pc_en  = opcode[0] ? zero : ~zero;
        state_d    = S_FETCH;
      end
      S_IMMEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = dec_alu_op;
        state_d       = S_IMMWB;
      end
      S_IMMWB: begin
        ctl.reg_write = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        ctl.pc_en  = 1'b1;
        ctl.pc_src = PCSRC_JUMP;
        state_d    = S_FETCH;
      end
      S_ERR: begin
        ctl.err = 1'b1;
      end
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal_c  = 1'b1;
        ctl.pc_en  = 1'b1;
        ctl.pc_src = PCSRC_JUMP;
        state_d    = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // Wait counter only runs while a request is stalled; any completion clears it.
    if (ctl.mem_req && !mem_ready) begin
      if (cnt_q == TO_LAST) state_d = S_ERR;
      else                  cnt_d   = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Asynchronous gating so a reset mid-access drops the request immediately.
  assign ctl_g      = reset_n ? ctl : '0;
  assign mem_req    = ctl_g.mem_req;
  assign mem_write  = ctl_g.mem_write;
  assign iord       = ctl_g.iord;
  assign ir_write   = ctl_g.ir_write;
  assign pc_en      = ctl_g.pc_en;
  assign pc_src     = ctl_g.pc_src;
  assign alu_src_a  = ctl_g.alu_src_a;
  assign alu_src_b  = ctl_g.alu_src_b;
  assign alu_op     = ctl_g.alu_op;
  assign reg_write  = ctl_g.reg_write;
  assign reg_dst    = ctl_g.reg_dst;
  assign mem_to_reg = ctl_g.mem_to_reg;
  assign err        = ctl_g.err;
  assign state_dbg  = state_q;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  assign illegal_op = reset_n & illegal_c;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: instruction sequences with hand-computed control outputs.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic       reg_write, reg_dst, mem_to_reg, err;
  logic [3:0] state_dbg;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mc_control #(.MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .err        (err),
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    .illegal_op (illegal_op),
`endif
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // FETCH with a zero-wait instruction read; returns one cycle later in DECODE.
  task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
    opcode = op; funct = fn; mem_ready = 1'b1; zero = 1'b0;
    #1;
    check("fetch_state", state_dbg, 4'd0);
    check("fetch_req", mem_req, 1'b1);
    check("fetch_iord", iord, 1'b0);
    check("fetch_irw", ir_write, 1'b1);
    check("fetch_pcen", pc_en, 1'b1);
    check("fetch_pcsrc", pc_src, 2'd0);
    check("fetch_srcb", alu_src_b, 2'd1);
    check("fetch_aluop", alu_op, 4'b0010);
    cyc();
    check("decode_state", state_dbg, 4'd1);
    check("decode_srcb", alu_src_b, 2'd3);
    check("decode_aluop", alu_op, 4'b0010);
    check("decode_req", mem_req, 1'b0);
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [3:0] exp_op);
    fetch(6'b000000, fn);
    cyc();
    check("rtex_state", state_dbg, 4'd6);
    check("rtex_aluop", alu_op, exp_op);
    check("rtex_srca", alu_src_a, 1'b1);
    check("rtex_srcb", alu_src_b, 2'd0);
    cyc();
    check("rtwb_state", state_dbg, 4'd7);
    check("rtwb_regw", reg_write, 1'b1);
    check("rtwb_dst", reg_dst, 1'b1);
    check("rtwb_m2r", mem_to_reg, 1'b0);
    cyc();
    check("rt_back_fetch", state_dbg, 4'd0);
  endtask

  task automatic branch(input logic [5:0] op, input logic z, input logic exp_en);
    fetch(op, 6'd0);
    cyc();
    check("br_state", state_dbg, 4'd8);
    check("br_aluop", alu_op, 4'b0111);
    check("br_srca", alu_src_a, 1'b1);
    check("br_srcb", alu_src_b, 2'd0);
    check("br_pcen_c1", pc_en, 1'b0);
    cyc();
    zero = z;
    #1;
    check("brwait_state", state_dbg, 4'd9);
    check("brwait_pcsrc", pc_src, 2'd1);
    check("brwait_pcen", pc_en, exp_en);
    cyc();
    check("br_back_fetch", state_dbg, 4'd0);
  endtask

  task automatic imm(input logic [5:0] op, input logic [3:0] exp_op);
    fetch(op, 6'd0);
    cyc();
    check("immex_state", state_dbg, 4'd10);
    check("immex_aluop", alu_op, exp_op);
    check("immex_srcb", alu_src_b, 2'd2);
    cyc();
    check("immwb_regw", reg_write, 1'b1);
    check("immwb_dst", reg_dst, 1'b0);
    check("immwb_m2r", mem_to_reg, 1'b0);
    cyc();
    check("imm_back_fetch", state_dbg, 4'd0);
  endtask

  logic [5:0] fn_tab [8];
  logic [3:0] op_tab [8];
  int         req_cycles;

  initial begin
    fn_tab[0] = 6'b100100; op_tab[0] = 4'b0000;
    fn_tab[1] = 6'b100101; op_tab[1] = 4'b0001;
    fn_tab[2] = 6'b100000; op_tab[2] = 4'b0010;
    fn_tab[3] = 6'b100111; op_tab[3] = 4'b0011;
    fn_tab[4] = 6'b100010; op_tab[4] = 4'b0110;
    fn_tab[5] = 6'b000000; op_tab[5] = 4'b0100;
    fn_tab[6] = 6'b000010; op_tab[6] = 4'b0101;
    fn_tab[7] = 6'b000011; op_tab[7] = 4'b1000;

    reset_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) cyc();
    check("rst_state", state_dbg, 4'd0);
    check("rst_req", mem_req, 1'b0);
    check("rst_irw", ir_write, 1'b0);
    check("rst_aluop", alu_op, 4'd0);
    check("rst_err", err, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) rtype(fn_tab[i], op_tab[i]);

    // Unknown funct 111111.
    fetch(6'b000000, 6'b111111);
    cyc();
    check("rtex_unk_aluop", alu_op, 4'b0010);
    cyc();
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    check("trap_f_state", state_dbg, 4'd14);
    check("trap_f_ill", illegal_op, 1'b1);
    check("trap_f_regw", reg_write, 1'b0);
    check("trap_f_pcsrc", pc_src, 2'd2);
`else
    check("rtwb_unk_regw", reg_write, 1'b1);
`endif
    cyc();
    check("unk_fn_fetch", state_dbg, 4'd0);

    // lw with three wait cycles in MEMRD.
    fetch(6'b100011, 6'd0);
    mem_ready = 1'b0;
    cyc();
    check("memadr_state", state_dbg, 4'd2);
    check("memadr_srcb", alu_src_b, 2'd2);
    check("memadr_aluop", alu_op, 4'b0010);
    cyc();
    req_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      check("memrd_wait_state", state_dbg, 4'd3);
      check("memrd_iord", iord, 1'b1);
      if (mem_req === 1'b1) req_cycles++;
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    if (mem_req === 1'b1) req_cycles++;
    check("memrd_req_cycles", req_cycles, 4);
    cyc();
    check("memwb_state", state_dbg, 4'd4);
    check("memwb_m2r", mem_to_reg, 1'b1);
    check("memwb_regw", reg_write, 1'b1);
    check("memwb_dst", reg_dst, 1'b0);
    cyc();
    check("lw_back_fetch", state_dbg, 4'd0);

    // sw with a zero-wait data access.
    fetch(6'b101011, 6'd0);
    cyc();
    cyc();
    check("memwr_state", state_dbg, 4'd5);
    check("memwr_write", mem_write, 1'b1);
    check("memwr_iord", iord, 1'b1);
    cyc();
    check("sw_back_fetch", state_dbg, 4'd0);

    branch(6'b000100, 1'b0, 1'b1);
    branch(6'b000100, 1'b1, 1'b0);
    branch(6'b000101, 1'b0, 1'b0);
    branch(6'b000101, 1'b1, 1'b1);

    imm(6'b001000, 4'b0010);
    imm(6'b001100, 4'b0000);
    imm(6'b001101, 4'b0001);

    fetch(6'b000010, 6'd0);
    cyc();
    check("jump_state", state_dbg, 4'd12);
    check("jump_pcen", pc_en, 1'b1);
    check("jump_pcsrc", pc_src, 2'd2);
    cyc();
    check("jump_back_fetch", state_dbg, 4'd0);

    // Illegal opcode 111111.
    fetch(6'b111111, 6'd0);
    check("illop_dec_regw", reg_write, 1'b0);
    cyc();
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    check("trap_state", state_dbg, 4'd14);
    check("trap_ill", illegal_op, 1'b1);
    check("trap_pcen", pc_en, 1'b1);
    check("trap_pcsrc", pc_src, 2'd2);
    cyc();
    check("trap_ill_drop", illegal_op, 1'b0);
`endif
    check("illop_fetch", state_dbg, 4'd0);
    check("illop_regw", reg_write, 1'b0);

    // Reset asserted while MEMWR is waiting.
    fetch(6'b101011, 6'd0);
    mem_ready = 1'b0;
    cyc();
    cyc();
    check("memwr_wait_req", mem_req, 1'b1);
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_req", mem_req, 1'b0);
    check("rst_mid_write", mem_write, 1'b0);
    cyc();
    reset_n = 1'b1;
    #1;
    check("rst_mid_state", state_dbg, 4'd0);

    // Fetch timeout: four stalled cycles reach ERR.
    mem_ready = 1'b0;
    #1;
    check("to_fetch_pcen", pc_en, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("to_still_fetch", state_dbg, 4'd0);
    end
    cyc();
    check("to_err", err, 1'b1);
    check("to_err_req", mem_req, 1'b0);
    check("to_err_pcen", pc_en, 1'b0);
    mem_ready = 1'b1;
    repeat (3) cyc();
    check("to_err_sticky", err, 1'b1);
    reset_n = 1'b0;
    #1;
    check("to_err_clear", err, 1'b0);
    cyc();
    reset_n = 1'b1;
    #1;
    check("to_after_rst", state_dbg, 4'd0);
    check("to_after_req", mem_req, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
